// File: rtl/uart_cmd_pkg.sv
// Shared command codes, state encoding and widths for the UART command decoder.
package uart_cmd_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 2;

  typedef enum logic [CTRL_W-1:0] {
    CMD_ADDR  = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_READ  = 2'b10,
    CMD_RUN   = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MEM_WR  = 3'd1,
    MEM_RD  = 3'd2,
    TX_SEND = 3'd3,
    TX_WAIT = 3'd4
  } state_e;

endpackage

// File: rtl/uart_cmd_decoder.sv
// Decodes UART command words into Avalon-MM accesses, read-back transmits and core reset control.
// Define UART_CMD_ECHO_EN to echo every accepted write word back over the UART as an acknowledge.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned ADDR_STEP = 4,
  parameter logic        RST_VALUE = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] rx_data,
  input  logic [CTRL_W-1:0] rx_ctrl,
  input  logic              rx_done,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_flag,
  input  logic              tx_done,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_waitrequest,
  output logic              cpu_reset,
  output logic              busy,
  output logic              err_overrun
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_read_q, mem_read_d;
  logic              tx_flag_q, tx_flag_d;
  logic              busy_q, busy_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              err_q, err_d;

  // State and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      wdata_q     <= '0;
      tx_data_q   <= '0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      tx_flag_q   <= 1'b0;
      busy_q      <= 1'b0;
      cpu_reset_q <= RST_VALUE;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      wdata_q     <= wdata_d;
      tx_data_q   <= tx_data_d;
      mem_write_q <= mem_write_d;
      mem_read_q  <= mem_read_d;
      tx_flag_q   <= tx_flag_d;
      busy_q      <= busy_d;
      cpu_reset_q <= cpu_reset_d;
      err_q       <= err_d;
    end
  end

  // Next-state and datapath decode; registered strobes follow the next state
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    wdata_d     = wdata_q;
    tx_data_d   = tx_data_q;
    cpu_reset_d = cpu_reset_q;
    err_d       = err_q | (rx_done & (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (rx_done) begin
          case (cmd_e'(rx_ctrl))
            CMD_ADDR:  ptr_d = rx_data;
            CMD_WRITE: begin
              wdata_d = rx_data;
              state_d = MEM_WR;
            end
            CMD_READ:  state_d = MEM_RD;
            CMD_RUN:   cpu_reset_d = rx_data[0];
            default:   state_d = IDLE;
          endcase
        end
      end
      MEM_WR: begin
        if (!mem_waitrequest) begin
          ptr_d = ptr_q + DATA_W'(ADDR_STEP);
`ifdef UART_CMD_ECHO_EN
          tx_data_d = wdata_q;
          state_d   = TX_SEND;
`else
          state_d   = IDLE;
`endif
        end
      end
      MEM_RD: begin
        if (!mem_waitrequest) begin
          ptr_d     = ptr_q + DATA_W'(ADDR_STEP);
          tx_data_d = mem_rdata;
          state_d   = TX_SEND;
        end
      end
      TX_SEND: state_d = TX_WAIT;
      TX_WAIT: begin
        if (tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    mem_write_d = (state_d == MEM_WR);
    mem_read_d  = (state_d == MEM_RD);
    tx_flag_d   = (state_d == TX_SEND);
    busy_d      = (state_d != IDLE);
  end

  assign tx_data     = tx_data_q;
  assign tx_flag     = tx_flag_q;
  assign mem_addr    = ptr_q;
  assign mem_wdata   = wdata_q;
  assign mem_write   = mem_write_q;
  assign mem_read    = mem_read_q;
  assign cpu_reset   = cpu_reset_q;
  assign busy        = busy_q;
  assign err_overrun = err_q;

endmodule

// File: doc/uart_cmd_decoder.md
UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 SHALL have parameter ADDR_STEP, default 4, the address increment after each data write or read.
REQ-002 SHALL have parameter RST_VALUE, default 1'b1, the reset value of cpu_reset.
REQ-003 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port rx_data, input, 32, received payload word.
REQ-006 SHALL have port rx_ctrl, input, 2, received command code.
REQ-007 SHALL have port rx_done, input, 1, one-cycle pulse; rx_data and rx_ctrl are valid in that cycle.
REQ-008 SHALL have port tx_data, output, 32, word to transmit.
REQ-009 SHALL have port tx_flag, output, 1, one-cycle transmit-start pulse.
REQ-010 SHALL have port tx_done, input, 1, one-cycle pulse at transmit completion.
REQ-011 SHALL have port mem_addr, output, 32, Avalon-MM master address.
REQ-012 SHALL have port mem_wdata, output, 32, write data.
REQ-013 SHALL have port mem_write, output, 1, write request.
REQ-014 SHALL have port mem_read, output, 1, read request.
REQ-015 SHALL have port mem_rdata, input, 32, read data, valid in the cycle the read is accepted.
REQ-016 SHALL have port mem_waitrequest, input, 1, slave stall.
REQ-017 SHALL have port cpu_reset, output, 1, level reset to the core.
REQ-018 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-019 SHALL have port err_overrun, output, 1, sticky flag for a dropped command.

Function
REQ-020 SHALL implement FSM states IDLE, MEM_WR, MEM_RD, TX_SEND, TX_WAIT.
REQ-021 SHALL, in IDLE with rx_done, decode rx_ctrl: 00 sets the address pointer to rx_data and stays in IDLE; 01 goes to MEM_WR; 10 goes to MEM_RD; 11 sets cpu_reset to rx_data[0] and stays in IDLE.
REQ-022 SHALL assert mem_write, with mem_wdata equal to the captured rx_data, from the cycle after rx_done; mem_addr, mem_wdata and mem_write SHALL stay stable while mem_waitrequest is high.
REQ-023 SHALL treat a write as accepted in a cycle with mem_write high and mem_waitrequest low; the pointer SHALL then advance by ADDR_STEP and the FSM SHALL return to IDLE.
REQ-024 SHALL issue reads the same way with mem_read; on acceptance it SHALL capture mem_rdata into tx_data, advance the pointer, and go to TX_SEND.
REQ-025 SHALL, in TX_SEND, pulse tx_flag for exactly one cycle and then go to TX_WAIT.
REQ-026 SHALL hold tx_data stable from TX_SEND until tx_done; tx_done SHALL return the FSM to IDLE.
REQ-027 SHALL wrap pointer advances modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000).
REQ-028 SHALL never assert mem_write and mem_read together.
REQ-029 SHALL drop any rx_done arriving while busy and set err_overrun; err_overrun SHALL clear only on RST.
REQ-030 SHALL ignore tx_done outside TX_WAIT.

Reset
REQ-031 SHALL, on RST, immediately enter IDLE and set pointer/mem_addr=0, mem_wdata=0, tx_data=0, mem_write=0, mem_read=0, tx_flag=0, busy=0, err_overrun=0, cpu_reset=RST_VALUE.
REQ-032 SHALL abandon any in-flight memory or transmit transaction on RST, with no completion pulse.

Configuration
REQ-033 SHALL, with UART_CMD_ECHO_EN defined, go from an accepted write to TX_SEND with tx_data equal to the written word, echoing it as an acknowledge.
REQ-034 SHALL, without UART_CMD_ECHO_EN, return an accepted write directly to IDLE with no transmission.

Structure
REQ-035 SHALL take the command codes (CMD_ADDR=00, CMD_WRITE=01, CMD_READ=10, CMD_RUN=11) and the state enum typedef from a shared package, uart_cmd_pkg.
REQ-036 SHALL be a single module with no sub-modules; it connects between the UART data_rx/controlBits/done_rx outputs and its data_tx/flag_tx/done_tx inputs.

Verification
REQ-037 SHALL cover: ADDR 0x100, then WRITE 0xDEADBEEF with waitrequest high for 3 cycles -> one write at 0x100 held for 4 cycles; pointer becomes 0x104.
REQ-038 SHALL cover: ADDR 0x100, then READ with mem_rdata=0x12345678 -> one tx_flag pulse with tx_data=0x12345678; busy until tx_done.
REQ-039 SHALL cover: ADDR 0xFFFFFFFC, then WRITE twice -> writes at 0xFFFFFFFC and 0x00000000.
REQ-040 SHALL cover: rx_done pulsed during TX_WAIT -> command ignored and err_overrun=1 until RST.
REQ-041 SHALL cover: after reset cpu_reset=1; RUN with data 0 -> cpu_reset=0; RUN with data 1 -> cpu_reset=1.
REQ-042 SHALL cover: RST asserted mid-write -> mem_write=0 the same cycle and all outputs at reset values.
